// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall sequencing for the 5-stage MIPS core; tracks in-flight destinations for forwarding.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   opcode_id,
  input  logic [ADDR_W-1:0] rs_id,
  input  logic [ADDR_W-1:0] rt_id,
  input  logic              uses_rs_id,
  input  logic              uses_rt_id,
  input  logic [ADDR_W-1:0] dst_id,
  input  logic              reg_write_id,
  input  logic              mem_read_id,
  input  logic              branch_taken_id,
  output logic              stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic [ADDR_W-1:0] rd_addr_ex,
  output logic [ADDR_W-1:0] rd_addr_exmem,
  output logic [ADDR_W-1:0] rd_addr_memwb,
  output logic              reg_write_ex,
  output logic              reg_write_exmem,
  output logic              reg_write_memwb,
  output logic              mem_read_ex,
  output logic              mem_read_exmem
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    BR_STALL2 = 2'b01,
    STALL1    = 2'b10
  } stateT;

  localparam logic [OP_W-1:0]   OP_BLTZ = OP_W'(6'h01);
  localparam logic [OP_W-1:0]   OP_BEQ  = OP_W'(6'h04);
  localparam logic [OP_W-1:0]   OP_BNE  = OP_W'(6'h05);
  localparam logic [OP_W-1:0]   OP_BLEZ = OP_W'(6'h06);
  localparam logic [OP_W-1:0]   OP_BGTZ = OP_W'(6'h07);
  localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};

  stateT state, nextState;

  logic isBrRsRt, isBrRsOnly, isBranch;
  logic useRs, useRt;
  logic matchEx, matchExMem;
  logic hazLu, hazBrx, hazBrl, hazBrm;

  assign isBrRsRt   = (opcode_id == OP_BEQ) || (opcode_id == OP_BNE);
  assign isBrRsOnly = (opcode_id == OP_BLTZ) || (opcode_id == OP_BLEZ) || (opcode_id == OP_BGTZ);
  assign isBranch   = isBrRsRt || isBrRsOnly;

  // A branch compares the registers its class defines, regardless of the decoder's use flags.
  assign useRs = isBranch ? 1'b1 : uses_rs_id;
  assign useRt = isBranch ? isBrRsRt : uses_rt_id;

  assign matchEx = reg_write_ex && (rd_addr_ex != ZERO_REG) &&
                   ((useRs && (rd_addr_ex == rs_id)) || (useRt && (rd_addr_ex == rt_id)));
  assign matchExMem = reg_write_exmem && (rd_addr_exmem != ZERO_REG) &&
                      ((useRs && (rd_addr_exmem == rs_id)) || (useRt && (rd_addr_exmem == rt_id)));

  assign hazLu  = mem_read_ex && matchEx;
  assign hazBrx = isBranch && !mem_read_ex && matchEx;
  assign hazBrl = isBranch && mem_read_ex && matchEx;
  assign hazBrm = isBranch && mem_read_exmem && matchExMem;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and Mealy stall/bubble decode.
  always_comb begin
    nextState   = state;
    stall       = 1'b0;
    idex_bubble = 1'b0;
    case (state)
      RUN, STALL1: begin
        if (hazBrl) begin
          nextState   = BR_STALL2;
          stall       = 1'b1;
          idex_bubble = 1'b1;
        end else if (hazLu || hazBrx || hazBrm) begin
          nextState   = STALL1;
          stall       = 1'b1;
          idex_bubble = 1'b1;
        end else begin
          nextState = RUN;
        end
      end
      BR_STALL2: begin
        nextState   = STALL1;
        stall       = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
        nextState = RUN;
      end
    endcase
  end

  // A stalled branch is flushed only on its retry, once its operands are resolved.
  assign ifid_flush = branch_taken_id && isBranch && !stall;

  // Destination tracking: ID->EX (bubble inserts a NOP), then EX->MEM->WB every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_ex      <= ZERO_REG;
      rd_addr_exmem   <= ZERO_REG;
      rd_addr_memwb   <= ZERO_REG;
      reg_write_ex    <= 1'b0;
      reg_write_exmem <= 1'b0;
      reg_write_memwb <= 1'b0;
      mem_read_ex     <= 1'b0;
      mem_read_exmem  <= 1'b0;
    end else begin
      if (idex_bubble) begin
        rd_addr_ex   <= ZERO_REG;
        reg_write_ex <= 1'b0;
        mem_read_ex  <= 1'b0;
      end else begin
        rd_addr_ex   <= dst_id;
        reg_write_ex <= reg_write_id;
        mem_read_ex  <= mem_read_id;
      end
      rd_addr_exmem   <= rd_addr_ex;
      reg_write_exmem <= reg_write_ex;
      mem_read_exmem  <= mem_read_ex;
      rd_addr_memwb   <= rd_addr_exmem;
      reg_write_memwb <= reg_write_exmem;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating stall-cycle and flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'h0000_0000;
      flush_count  <= 32'h0000_0000;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'h0000_0001;
      end
      if (ifid_flush && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'h0000_0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized bench for hazard_stall_unit against a stall-budget reference model.
// Exercises the HAZARD_PERF_CNT_EN counters when that macro is defined.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode_id;
  logic [4:0] rs_id, rt_id, dst_id;
  logic       uses_rs_id, uses_rt_id, reg_write_id, mem_read_id, branch_taken_id;
  logic       stall, idex_bubble, ifid_flush;
  logic [4:0] rd_addr_ex, rd_addr_exmem, rd_addr_memwb;
  logic       reg_write_ex, reg_write_exmem, reg_write_memwb, mem_read_ex, mem_read_exmem;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_stall_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .dst_id(dst_id),
    .reg_write_id(reg_write_id), .mem_read_id(mem_read_id), .branch_taken_id(branch_taken_id),
    .stall(stall), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .rd_addr_ex(rd_addr_ex), .rd_addr_exmem(rd_addr_exmem), .rd_addr_memwb(rd_addr_memwb),
    .reg_write_ex(reg_write_ex), .reg_write_exmem(reg_write_exmem), .reg_write_memwb(reg_write_memwb),
    .mem_read_ex(mem_read_ex), .mem_read_exmem(mem_read_exmem)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB; mPend = one more forced stall cycle owed.
  logic [4:0]  mDst[3];
  bit          mRw[3];
  bit          mMr[3];
  bit          mPend;
  int unsigned mStall, mFlush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 3; i++) begin
      mDst[i] = 5'd0; mRw[i] = 1'b0; mMr[i] = 1'b0;
    end
    mPend = 1'b0; mStall = 0; mFlush = 0;
  endtask

  function automatic bit isBr(input logic [5:0] op);
    return (op == 6'h01) || (op == 6'h04) || (op == 6'h05) || (op == 6'h06) || (op == 6'h07);
  endfunction

  // Cycles the ID instruction must wait until every operand it needs is obtainable.
  function automatic int needStalls();
    bit         br, two;
    bit         used[2];
    logic [4:0] regs[2];
    int         n;
    br = isBr(opcode_id);
    two = (opcode_id == 6'h04) || (opcode_id == 6'h05);
    used[0] = br || uses_rs_id;
    used[1] = br ? two : uses_rt_id;
    regs[0] = rs_id;
    regs[1] = rt_id;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && regs[i] != 5'd0) begin
        if (mRw[0] && mDst[0] == regs[i]) begin
          if (mMr[0]) n = (n > (br ? 2 : 1)) ? n : (br ? 2 : 1);
          else if (br) n = (n > 1) ? n : 1;
        end
        if (br && mRw[1] && mMr[1] && mDst[1] == regs[i]) n = (n > 1) ? n : 1;
      end
    end
    return n;
  endfunction

  task automatic setId(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic tk);
    opcode_id = op; rs_id = rs; rt_id = rt; uses_rs_id = urs; uses_rt_id = urt;
    dst_id = dst; reg_write_id = rw; mem_read_id = mr; branch_taken_id = tk;
  endtask

  // One cycle: check against model mid-cycle, clock, advance model, return to negedge.
  task automatic step();
    int n;
    bit st, fl;
    #1;
    n = 0;
    if (mPend) st = 1'b1;
    else begin
      n = needStalls();
      st = (n > 0);
    end
    fl = branch_taken_id && isBr(opcode_id) && !st;
    chk("stall", 32'(stall), 32'(st));
    chk("idex_bubble", 32'(idex_bubble), 32'(st));
    chk("ifid_flush", 32'(ifid_flush), 32'(fl));
    chk("rd_addr_ex", 32'(rd_addr_ex), 32'(mDst[0]));
    chk("rd_addr_exmem", 32'(rd_addr_exmem), 32'(mDst[1]));
    chk("rd_addr_memwb", 32'(rd_addr_memwb), 32'(mDst[2]));
    chk("reg_write_ex", 32'(reg_write_ex), 32'(mRw[0]));
    chk("reg_write_exmem", 32'(reg_write_exmem), 32'(mRw[1]));
    chk("reg_write_memwb", 32'(reg_write_memwb), 32'(mRw[2]));
    chk("mem_read_ex", 32'(mem_read_ex), 32'(mMr[0]));
    chk("mem_read_exmem", 32'(mem_read_exmem), 32'(mMr[1]));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, mStall);
    chk("flush_count", flush_count, mFlush);
`endif
    @(posedge clk);
    for (int i = 2; i > 0; i--) begin
      mDst[i] = mDst[i-1]; mRw[i] = mRw[i-1]; mMr[i] = mMr[i-1];
    end
    mDst[0] = st ? 5'd0 : dst_id;
    mRw[0]  = st ? 1'b0 : reg_write_id;
    mMr[0]  = st ? 1'b0 : mem_read_id;
    mPend   = !mPend && (n == 2);
    if (st) mStall++;
    if (fl) mFlush++;
    @(negedge clk);
  endtask

  logic [5:0] ops[8];

  initial begin
    ops = '{6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h23, 6'h2b};
    rst_n = 1'b0;
    setId(6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    resetModel();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_rd_ex", 32'(rd_addr_ex), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    step();

    // Load-use: lw $8 then add reading $8.
    setId(6'h23, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    step();
    setId(6'h00, 5'd8, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_bubble", 32'(idex_bubble), 32'd1);
    step();
    #1 chk("lu_release", 32'(stall), 32'd0);
    chk("lu_ex_rw", 32'(reg_write_ex), 32'd0);
    chk("lu_exmem_rd", 32'(rd_addr_exmem), 32'd8);
    step();

    // ALU result in EX feeding a branch compare.
    setId(6'h00, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    setId(6'h04, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("brx_stall", 32'(stall), 32'd1);
    step();
    #1 chk("brx_release", 32'(stall), 32'd0);
    chk("brx_exmem_rd", 32'(rd_addr_exmem), 32'd9);
    step();

    // Load in EX feeding a bne rt: two stall cycles.
    setId(6'h23, 5'd1, 5'd10, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    step();
    setId(6'h05, 5'd1, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("brl_stall_a", 32'(stall), 32'd1);
    step();
    #1 chk("brl_stall_b", 32'(stall), 32'd1);
    step();
    #1 chk("brl_release", 32'(stall), 32'd0);
    step();

    // Register zero and unused operands never stall.
    setId(6'h23, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step();
    setId(6'h00, 5'd0, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1 chk("r0_nostall", 32'(stall), 32'd0);
    step();
    setId(6'h23, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    step();
    setId(6'h00, 5'd8, 5'd1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    #1 chk("unused_nostall", 32'(stall), 32'd0);
    step();

    // Taken branch flushes; with a hazard the flush waits for the retry.
    setId(6'h04, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("flush_plain", 32'(ifid_flush), 32'd1);
    step();
    setId(6'h00, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    setId(6'h04, 5'd5, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("flush_held", 32'(ifid_flush), 32'd0);
    chk("flush_held_stall", 32'(stall), 32'd1);
    step();
    #1 chk("flush_retry", 32'(ifid_flush), 32'd1);
    step();

    // Reset asserted during BR_STALL2.
    setId(6'h23, 5'd1, 5'd10, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    step();
    setId(6'h05, 5'd1, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    #1 chk("pre_rst_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bubble", 32'(idex_bubble), 32'd0);
    chk("rst_flush", 32'(ifid_flush), 32'd0);
    chk("rst_rd_exmem", 32'(rd_addr_exmem), 32'd0);
    chk("rst_mr_ex", 32'(mem_read_ex), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    step();

    // Randomized traffic over a small register set to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      setId(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
